debounce_bank: RTL and testbench

//  Multi-channel switch/button debouncer for the Laboratorio2 board I/O.

---
 rtl/debounce_bank.sv | 124 ++++++++++++
 tb/tb_debounce_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch/button debouncer.
// Every channel runs independently through a synchroniser chain, a settle
// counter, a registered clean level and one-cycle rise/fall strobes.
// Optional long-press detection is compiled in with `define DEBOUNCE_HOLD_EN;
// without it the hold outputs are tied low and the port list is unchanged.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int DELAY       = 270000,
    parameter int CNT_W       = 19,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_DELAY  = 27000000,
    parameter int HOLD_W      = 25
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic                   cand_reg;
            logic [CNT_W-1:0]       count_reg;
            logic                   clean_reg;
            logic                   clean_next;
            logic                   rise_reg;
            logic                   fall_reg;

            assign s = sync_reg[SYNC_STAGES-1];

            // Shift the raw pin level through the synchroniser chain.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], noisy[gi]};
                end
            end

            // Track the candidate level and how long it has been stable;
            // any change restarts the count, and a settled count saturates.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cand_reg  <= 1'b0;
                    count_reg <= '0;
                end else if (s != cand_reg) begin
                    cand_reg  <= s;
                    count_reg <= '0;
                end else if (count_reg != DELAY_C) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            // The candidate is accepted once it has survived the full settle time.
            always_comb begin
                clean_next = clean_reg;
                if ((s == cand_reg) && (count_reg == DELAY_C)) begin
                    clean_next = cand_reg;
                end
            end

            // Register the clean level together with its edge strobes so
            // rise/fall line up exactly with the first cycle of the new level.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    clean_reg <= clean_next;
                    rise_reg  <= clean_next & ~clean_reg;
                    fall_reg  <= ~clean_next & clean_reg;
                end
            end

            assign clean[gi] = clean_reg;
            assign rise[gi]  = rise_reg;
            assign fall[gi]  = fall_reg;

`ifdef DEBOUNCE_HOLD_EN
            localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(HOLD_DELAY);

            logic [HOLD_W-1:0] hold_cnt_reg;
            logic [HOLD_W-1:0] hold_cnt_next;
            logic              hold_reg;

            // Count cycles spent pressed; the count is dropped in the same
            // cycle the clean level falls so hold clears alongside fall.
            always_comb begin
                hold_cnt_next = hold_cnt_reg;
                if (!clean_next) begin
                    hold_cnt_next = '0;
                end else if (clean_reg && (hold_cnt_reg != HOLD_C)) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end

            // Long-press flag is high while the saturated count is held.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    hold_cnt_reg <= '0;
                    hold_reg     <= 1'b0;
                end else begin
                    hold_cnt_reg <= hold_cnt_next;
                    hold_reg     <= clean_next && (hold_cnt_next == HOLD_C);
                end
            end

            assign hold[gi] = hold_reg;
`else
            assign hold[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (DELAY=8, 2 sync stages, 4 channels,
// HOLD_DELAY=20). Long-press expectations follow DEBOUNCE_HOLD_EN.
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int DLY = 8;
    localparam int HD  = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] noisy = '0;
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] hold;

    debounce_bank #(
        .CHANNELS   (CH),
        .DELAY      (DLY),
        .CNT_W      (4),
        .SYNC_STAGES(2),
        .HOLD_DELAY (HD),
        .HOLD_W     (5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .noisy(noisy),
        .clean(clean),
        .rise (rise),
        .fall (fall),
        .hold (hold)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CH-1:0] clean;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] hold;
    } exp_t;

    typedef struct {
        logic [CH-1:0] in;
        int            cycles;
        logic [CH-1:0] exp_clean;
        logic [CH-1:0] exp_rises;
        logic [CH-1:0] exp_falls;
        string         name;
    } step_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    // Reference: samples taken at each edge; clean takes value v once the
    // last DLY+2 samples (ignoring the two newest, still in the synchroniser)
    // all equal v.
    logic [CH-1:0] hist [0:DLY+3];
    logic [CH-1:0] m_clean = '0;
    int            m_hc [CH];
    int            rcnt [CH];
    int            fcnt [CH];

    task automatic check(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    // Predict outputs after the coming edge and push them to the scoreboard.
    task automatic model_edge();
        exp_t          e;
        logic [CH-1:0] nc;
        logic          v;
        logic          stable;
        if (reset) begin
            for (int j = 0; j <= DLY + 3; j++) hist[j] = '0;
            for (int c = 0; c < CH; c++) m_hc[c] = 0;
            m_clean = '0;
            e.clean = '0; e.rise = '0; e.fall = '0; e.hold = '0;
        end else begin
            for (int j = DLY + 3; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = noisy;
            nc = m_clean;
            for (int c = 0; c < CH; c++) begin
                v      = hist[2][c];
                stable = 1'b1;
                for (int j = 2; j <= DLY + 3; j++) if (hist[j][c] != v) stable = 1'b0;
                if (stable) nc[c] = v;
            end
            e.hold = '0;
            for (int c = 0; c < CH; c++) begin
                if (!nc[c]) m_hc[c] = 0;
                else if (m_clean[c] && m_hc[c] < HD) m_hc[c]++;
`ifdef DEBOUNCE_HOLD_EN
                e.hold[c] = nc[c] && (m_hc[c] == HD);
`endif
            end
            e.clean = nc;
            e.rise  = nc & ~m_clean;
            e.fall  = m_clean & ~nc;
            m_clean = nc;
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, compare away from the edge.
    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty at cycle %0d: got no entry, expected one", cyc);
        end else begin
            e = sb_q.pop_front();
            check("sb_clean", clean, e.clean);
            check("sb_rise",  rise,  e.rise);
            check("sb_fall",  fall,  e.fall);
            check("sb_hold",  hold,  e.hold);
        end
        check("rise_fall_exclusive", rise & fall, '0);
        for (int c = 0; c < CH; c++) begin
            if (rise[c]) rcnt[c]++;
            if (fall[c]) fcnt[c]++;
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            rcnt[c] = 0;
            fcnt[c] = 0;
        end
    endtask

    // Tick until the selected strobe (0=rise,1=fall,2=hold) on ch; -1 on timeout.
    task automatic wait_for(input int sel, input int ch, output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (n < 40 && !found) begin
            tick();
            n++;
            if ((sel == 0 && rise[ch]) || (sel == 1 && fall[ch]) || (sel == 2 && hold[ch]))
                found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step_t         steps [7];
        logic [CH-1:0] rm;
        logic [CH-1:0] fm;
        logic [CH-1:0] multi;
        logic          prev_hold;
        int            n;

        steps[0] = '{4'b0001, 11, 4'b0000, 4'b0000, 4'b0000, "ch0_press_before_edge12"};
        steps[1] = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, "ch0_press_edge12"};
        steps[2] = '{4'b0011,  5, 4'b0001, 4'b0000, 4'b0000, "ch1_glitch_5_cycles"};
        steps[3] = '{4'b0001, 20, 4'b0001, 4'b0000, 4'b0000, "ch1_after_glitch"};
        steps[4] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b0001, "ch0_release"};
        steps[5] = '{4'b1010, 40, 4'b1010, 4'b1010, 4'b0000, "ch1_ch3_press"};
        steps[6] = '{4'b0000, 20, 4'b0000, 4'b0000, 4'b1010, "ch1_ch3_release"};

        for (int j = 0; j <= DLY + 3; j++) hist[j] = '0;
        for (int c = 0; c < CH; c++) m_hc[c] = 0;
        clear_counts();

        // Reset state, before any clock edge.
        #1;
        check("reset_clean", clean, '0);
        check("reset_rise",  rise,  '0);
        check("reset_fall",  fall,  '0);
        check("reset_hold",  hold,  '0);
        repeat (3) tick();
        reset = 1'b0;

        // Table-driven steps.
        for (int i = 0; i < 7; i++) begin
            noisy = steps[i].in;
            clear_counts();
            repeat (steps[i].cycles) tick();
            rm = '0; fm = '0; multi = '0;
            for (int c = 0; c < CH; c++) begin
                rm[c]    = (rcnt[c] == 1);
                fm[c]    = (fcnt[c] == 1);
                multi[c] = (rcnt[c] > 1) || (fcnt[c] > 1);
            end
            check({steps[i].name, "_clean"}, clean, steps[i].exp_clean);
            check({steps[i].name, "_rises"}, rm, steps[i].exp_rises);
            check({steps[i].name, "_falls"}, fm, steps[i].exp_falls);
            check({steps[i].name, "_multi"}, multi, '0);
            $display("step %0d %s noisy=%b clean=%b rises=%b falls=%b", i, steps[i].name, noisy, clean, rm, fm);
        end

        // Bouncing channel 2: 1/0 every 3 cycles for 30 cycles, then held 1.
        clear_counts();
        for (int seg = 0; seg < 10; seg++) begin
            noisy = (seg % 2 == 0) ? 4'b0100 : 4'b0000;
            repeat (3) tick();
        end
        check_int("bounce_no_rise", rcnt[2], 0);
        noisy = 4'b0100;
        wait_for(0, 2, n);
        check_int("bounce_settle_edges", n, 12);
        repeat (2) tick();
        check_int("bounce_single_rise", rcnt[2], 1);
        check("bounce_clean", clean, 4'b0100);
        $display("seq bounce ch2 settled after %0d edges clean=%b", n, clean);
        noisy = 4'b0000;
        repeat (20) tick();

        // Reset in the middle of channel 0 settling, channel 1 already high.
        noisy = 4'b0010;
        repeat (20) tick();
        noisy = 4'b0011;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        check("midreset_clean", clean, '0);
        check("midreset_rise",  rise,  '0);
        check("midreset_fall",  fall,  '0);
        check("midreset_hold",  hold,  '0);
        repeat (3) tick();
        reset = 1'b0;
        wait_for(0, 0, n);
        check_int("postreset_edges", n, 12);
        check("postreset_rise", rise, 4'b0011);
        $display("seq midreset: ch0 rose %0d edges after release rise=%b", n, rise);

        // Long press on channel 3.
        noisy = 4'b0000;
        repeat (20) tick();
        noisy = 4'b1000;
        wait_for(0, 3, n);
        check_int("hold_press_edges", n, 12);
`ifdef DEBOUNCE_HOLD_EN
        wait_for(2, 3, n);
        check_int("hold_edges", n, HD);
`else
        clear_counts();
        repeat (30) tick();
        check("hold_disabled", hold, '0);
        n = -1;
`endif
        $display("seq hold ch3 hold after %0d edges hold=%b", n, hold);
        noisy     = 4'b0000;
        prev_hold = hold[3];
        n         = 0;
        while (n < 40 && !fall[3]) begin
            prev_hold = hold[3];
            tick();
            n++;
        end
        check_int("release_fall_edges", fall[3] ? n : -1, 12);
        check("release_hold_cleared", hold, '0);
`ifdef DEBOUNCE_HOLD_EN
        check_int("release_hold_before", int'(prev_hold), 1);
`else
        check_int("release_hold_before", int'(prev_hold), 0);
`endif
        $display("seq release ch3 fall after %0d edges hold=%b", n, hold);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
